stream_unpacker: RTL

- Width down-converter on the stb/ack stream interface.
- Accepts wide words (RATIO x OUT_WIDTH bits) from an upstream producer, typically a fifo output port, and emits them as RATIO consecutive narrow slices.
- Sits between wide buffering and narrow consumers, e.g. 32-bit fifo to byte-wide UART/serial transmitters.
- Flags the final slice of each word.

---
 rtl/stream_pkg.sv | 29 ++
 rtl/stream_slice_mux.sv | 38 +++
 rtl/stream_unpacker.sv | 107 ++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for stb/ack stream blocks.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   state_t - two-state stream FSM encoding (IDLE=1'b0, SEND=1'b1)
//   clog2   - ceiling log2 constant function, shared with the fifo and
//             later stream blocks
package stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_slice_mux.sv
// Selects one OUT_WIDTH slice of a wide word by slice index.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller owns the handshake and holds idx steady.
//
// Ports:
//   word  - wide word, OUT_WIDTH*RATIO bits
//   idx   - slice index, IDX_W bits; values >= RATIO select zero
//   slice - selected slice, OUT_WIDTH bits
//
// Build option STREAM_UNPACKER_MSB_FIRST_EN: when defined, index 0 selects
// the most significant slice; otherwise index 0 selects the least
// significant slice.
module stream_slice_mux #(
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = 4,
    parameter int IDX_W     = 2
) (
    input  logic [OUT_WIDTH*RATIO-1:0] word,
    input  logic [IDX_W-1:0]           idx,
    output logic [OUT_WIDTH-1:0]       slice
);

    // One-hot compare per slice rather than a variable part-select, so the
    // index arithmetic never needs widening and maps to a plain AND-OR mux.
    always_comb begin
        slice = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (idx == IDX_W'(k)) begin
`ifdef STREAM_UNPACKER_MSB_FIRST_EN
                slice = word[(RATIO-1-k)*OUT_WIDTH +: OUT_WIDTH];
`else
                slice = word[k*OUT_WIDTH +: OUT_WIDTH];
`endif
            end
        end
    end

endmodule

// File: rtl/stream_unpacker.sv
// Width down-converter: one wide stb/ack word out as RATIO narrow slices.
// Latency: slice 0 is presented the cycle after the input transfer; one slice per cycle sustained.
// Backpressure: data_out_ack low freezes slice/idx; data_in_ack is low until the last slice goes.
//
// Ports:
//   clk           - clock, all state on rising edge
//   rst           - asynchronous active-low reset
//   data_in       - wide input word, OUT_WIDTH*RATIO bits
//   data_in_stb   - producer has a word
//   data_in_ack   - block takes data_in this cycle
//   data_out      - current slice, OUT_WIDTH bits
//   data_out_stb  - data_out valid
//   data_out_ack  - consumer takes data_out this cycle
//   data_out_last - current slice is the last of its word
//
// Build option STREAM_UNPACKER_MSB_FIRST_EN: emit slices most significant
// first. Handshake and timing are unchanged.
module stream_unpacker
    import stream_pkg::*;
#(
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [OUT_WIDTH*RATIO-1:0] data_in,
    input  logic                       data_in_stb,
    output logic                       data_in_ack,
    output logic [OUT_WIDTH-1:0]       data_out,
    output logic                       data_out_stb,
    input  logic                       data_out_ack,
    output logic                       data_out_last
);

    localparam int IDX_W = (RATIO > 1) ? clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    state_t                     state;
    logic [OUT_WIDTH*RATIO-1:0] hold;
    logic [IDX_W-1:0]           idx;

    logic valid;
    logic last_slice;
    logic in_xfer;
    logic out_xfer;

    assign valid      = (state == SEND);
    assign last_slice = (idx == LAST_IDX);

    // data_out_ack reaches data_in_ack combinationally so a new word can be
    // taken on the same edge the final slice leaves: no bubble between words.
    assign data_in_ack = ~valid | (data_out_ack & last_slice);

    assign in_xfer  = data_in_stb & data_in_ack;
    assign out_xfer = valid & data_out_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            hold  <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        hold  <= data_in;
                        idx   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (out_xfer) begin
                        if (!last_slice) begin
                            idx <= idx + IDX_W'(1);
                        end else if (in_xfer) begin
                            hold <= data_in;
                            idx  <= '0;
                        end else begin
                            idx   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    stream_slice_mux #(
        .OUT_WIDTH (OUT_WIDTH),
        .RATIO     (RATIO),
        .IDX_W     (IDX_W)
    ) u_slice_mux (
        .word  (hold),
        .idx   (idx),
        .slice (data_out)
    );

    assign data_out_stb = valid;
    // Gated by valid so last reads 0 in reset and idle, including RATIO=1
    // where idx==LAST_IDX always holds.
    assign data_out_last = valid & last_slice;

endmodule
